// File: rtl/nrdiv_pkg.sv
// Shared types and helpers for the nrdiv_seq sequential divider.
package nrdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } nrdiv_state_t;

    function automatic int nrdiv_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/nrdiv_step.sv
// One non-restoring iteration: shift {R,Q} left, add or subtract D by the sign of R,
// and retire the new quotient bit from the sign of the result.
module nrdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             add_sel
);

    logic [WIDTH:0] r_sh;

    // R only needs WIDTH+1 bits: the shifted value may wrap, but after the add/sub
    // the result is back in [-D, D) so modular arithmetic gives the right answer.
    assign add_sel = r[WIDTH];
    assign r_sh    = {r[WIDTH-1:0], q[WIDTH-1]};
    assign r_nxt   = add_sel ? (r_sh + {1'b0, d}) : (r_sh - {1'b0, d});
    assign q_nxt   = {q[WIDTH-2:0], ~r_nxt[WIDTH]};

endmodule

// File: rtl/nrdiv_seq.sv
// Parametrised sequential non-restoring divider, one quotient bit per cycle.
// Define NRDIV_SIGNED_EN to add the sgn input for two's complement operands.
module nrdiv_seq
    import nrdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = nrdiv_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef NRDIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [CNT_W-1:0] add_ops,
    output logic [CNT_W-1:0] sub_ops,
    output logic             dbz
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    nrdiv_state_t state, state_nxt;

    logic             load, dbz_load, step_en, fix_en;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q, d;
    logic [CNT_W-1:0] iter;

    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic             add_sel;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] rem_fix, q_out, r_out;

    // Handshake: start is sampled only in IDLE or DONE; done pulses one cycle on
    // entry to DONE; results hold until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dbz_load  = 1'b0;
        step_en   = 1'b0;
        fix_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dbz_load  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (iter == LAST_ITER) state_nxt = FIX;
            end
            FIX: begin
                fix_en    = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);

    nrdiv_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q       (q),
        .d       (d),
        .r_nxt   (r_step),
        .q_nxt   (q_step),
        .add_sel (add_sel)
    );

    // The final remainder is in [0, D), so the correction add fits in WIDTH bits.
    assign rem_fix = r[WIDTH] ? (r[WIDTH-1:0] + d) : r[WIDTH-1:0];

`ifdef NRDIV_SIGNED_EN
    logic neg_q, neg_r;

    assign op_a  = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign op_b  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign q_out = neg_q ? -q : q;
    assign r_out = neg_r ? -rem_fix : rem_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            neg_q <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn && dividend[WIDTH-1];
        end
    end
`else
    assign op_a  = dividend;
    assign op_b  = divisor;
    assign q_out = q;
    assign r_out = rem_fix;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            iter      <= '0;
            quotient  <= '0;
            remainder <= '0;
            add_ops   <= '0;
            sub_ops   <= '0;
            dbz       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fix_en | dbz_load;
            if (load) begin
                r       <= '0;
                q       <= op_a;
                d       <= op_b;
                iter    <= '0;
                add_ops <= '0;
                sub_ops <= '0;
                dbz     <= 1'b0;
            end
            if (dbz_load) begin
                quotient  <= '1;
                remainder <= dividend;
                add_ops   <= '0;
                sub_ops   <= '0;
                dbz       <= 1'b1;
            end
            if (step_en) begin
                r    <= r_step;
                q    <= q_step;
                iter <= iter + CNT_ONE;
                if (add_sel) add_ops <= add_ops + CNT_ONE;
                else         sub_ops <= sub_ops + CNT_ONE;
            end
            if (fix_en) begin
                if (r[WIDTH]) add_ops <= add_ops + CNT_ONE;
                quotient  <= q_out;
                remainder <= r_out;
            end
        end
    end

endmodule

// File: tb/tb_nrdiv_seq.sv
// Directed bench for nrdiv_seq: a 4-bit and an 8-bit instance driven from a vector
// table, plus hand-written sequences for mid-run start, reset abort and back-to-back.
module tb_nrdiv_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, start8;
    logic [7:0] a8, b8;
`ifdef NRDIV_SIGNED_EN
    logic       sgn;
`endif

    logic       busy4, done4, dbz4;
    logic [3:0] q4, r4;
    logic [2:0] add4, sub4;
    logic       busy8, done8, dbz8;
    logic [7:0] q8, r8;
    logic [3:0] add8, sub8;

    nrdiv_seq #(.WIDTH(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .dividend  (a8[3:0]),
        .divisor   (b8[3:0]),
`ifdef NRDIV_SIGNED_EN
        .sgn       (sgn),
`endif
        .busy      (busy4),
        .done      (done4),
        .quotient  (q4),
        .remainder (r4),
        .add_ops   (add4),
        .sub_ops   (sub4),
        .dbz       (dbz4)
    );

    nrdiv_seq #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .dividend  (a8),
        .divisor   (b8),
`ifdef NRDIV_SIGNED_EN
        .sgn       (sgn),
`endif
        .busy      (busy8),
        .done      (done8),
        .quotient  (q8),
        .remainder (r8),
        .add_ops   (add8),
        .sub_ops   (sub8),
        .dbz       (dbz8)
    );

    // View of whichever instance the current transaction targets.
    bit         sel;
    logic       s_busy, s_done, s_dbz;
    logic [7:0] s_q, s_r;
    logic [3:0] s_add, s_sub;

    always_comb begin
        if (sel) begin
            s_busy = busy8; s_done = done8; s_dbz = dbz8;
            s_q = q8; s_r = r8; s_add = add8; s_sub = sub8;
        end else begin
            s_busy = busy4; s_done = done4; s_dbz = dbz4;
            s_q = {4'b0, q4}; s_r = {4'b0, r4}; s_add = {1'b0, add4}; s_sub = {1'b0, sub4};
        end
    end

    typedef struct {
        bit         w8;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eq;
        logic [7:0] er;
        bit         edbz;
        bit         cnt_chk;
        int         eadd;
        int         esub;
        bit         sg;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Called at a negedge; the following posedge samples start.
    task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit sg);
        sel = w8;
        a8  = a;
        b8  = b;
`ifdef NRDIV_SIGNED_EN
        sgn = sg;
`else
        if (sg) $display("note: signed vector skipped without NRDIV_SIGNED_EN");
`endif
        if (w8) start8 = 1'b1;
        else    start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Entered in cycle 1 after the accepting edge; leaves at the done cycle.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (s_busy) bcnt++;
            if (s_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, bcnt, w;
        logic [15:0] exp;
        w = v.w8 ? 8 : 4;
        exp_q.push_back({v.eq, v.er});
        @(negedge clk);
        issue(v.w8, v.a, v.b, v.sg);
        wait_done(lat, bcnt);
        exp = exp_q.pop_front();
        check("latency", lat, v.edbz ? 1 : w + 2);
        check("busy_cycles", bcnt, v.edbz ? 0 : w + 1);
        check("quotient", s_q, exp[15:8]);
        check("remainder", s_r, exp[7:0]);
        check("dbz", s_dbz, v.edbz);
        if (v.cnt_chk) begin
            check("add_ops", s_add, v.eadd);
            check("sub_ops", s_sub, v.esub);
        end else begin
            check("ops_total_in_range", ((s_add + s_sub) >= w) && ((s_add + s_sub) <= w + 1), 1);
        end
        @(negedge clk);
        check("done_single_pulse", s_done, 0);
    endtask

    initial begin
        int lat, bcnt, seen;

        //                 w8    a      b      eq      er      dbz   chk   add sub sg
        tbl.push_back('{1'b0, 8'd7,   8'd2,   8'd3,   8'd1,   1'b0, 1'b1, 2, 2, 1'b0});
        tbl.push_back('{1'b0, 8'd15,  8'd1,   8'd15,  8'd0,   1'b0, 1'b1, 0, 4, 1'b0});
        tbl.push_back('{1'b0, 8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 1'b1, 4, 1, 1'b0});
        tbl.push_back('{1'b0, 8'd15,  8'd15,  8'd1,   8'd0,   1'b0, 1'b1, 3, 1, 1'b0});
        tbl.push_back('{1'b0, 8'd9,   8'd0,   8'd15,  8'd9,   1'b1, 1'b1, 0, 0, 1'b0});
        tbl.push_back('{1'b0, 8'd13,  8'd4,   8'd3,   8'd1,   1'b0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1'b1, 0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 0, 0, 1'b0});
`ifdef NRDIV_SIGNED_EN
        tbl.push_back('{1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 0, 0, 1'b1});
        tbl.push_back('{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b0, 0, 0, 1'b1});
        tbl.push_back('{1'b1, 8'd7,   8'hFE,  8'hFD,  8'd1,   1'b0, 1'b0, 0, 0, 1'b1});
        tbl.push_back('{1'b1, 8'h9C,  8'd0,   8'hFF,  8'h9C,  1'b1, 1'b1, 0, 0, 1'b1});
        sgn = 1'b0;
`endif

        rst = 1'b1; start4 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q4", q4, 0);       check("rst_r4", r4, 0);
        check("rst_busy4", busy4, 0); check("rst_done4", done4, 0);
        check("rst_dbz4", dbz4, 0);   check("rst_add4", add4, 0); check("rst_sub4", sub4, 0);
        check("rst_q8", q8, 0);       check("rst_r8", r8, 0);
        check("rst_busy8", busy8, 0); check("rst_done8", done8, 0);
        check("rst_dbz8", dbz8, 0);   check("rst_add8", add8, 0); check("rst_sub8", sub8, 0);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // 100/7 with a 9/3 start pulsed during RUN: the second start must be ignored.
        @(negedge clk);
        issue(1'b1, 8'd100, 8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(lat, bcnt);
        check("midrun_latency", lat + 3, 10);
        check("midrun_quotient", q8, 14);
        check("midrun_remainder", r8, 2);
        check("midrun_dbz", dbz8, 0);

        // Reset three cycles into an operation aborts it with no done.
        @(negedge clk);
        issue(1'b1, 8'd100, 8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_q8", q8, 0);       check("abort_r8", r8, 0);
        check("abort_busy8", busy8, 0); check("abort_done8", done8, 0);
        check("abort_add8", add8, 0);   check("abort_sub8", sub8, 0);
        check("abort_q4", q4, 0);       check("abort_r4", r4, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            if (done8 || busy8) seen++;
            @(negedge clk);
        end
        check("abort_no_done", seen, 0);

        // 6/4 then 9/3 issued in its done cycle.
        issue(1'b1, 8'd6, 8'd4, 1'b0);
        wait_done(lat, bcnt);
        check("b2b_first_latency", lat, 10);
        check("b2b_first_quotient", q8, 1);
        check("b2b_first_remainder", r8, 2);
        issue(1'b1, 8'd9, 8'd3, 1'b0);
        wait_done(lat, bcnt);
        check("b2b_second_latency", lat, 10);
        check("b2b_second_quotient", q8, 3);
        check("b2b_second_remainder", r8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nrdiv_seq.md
Name: nrdiv_seq

Overview:
- Parametrised sequential non-restoring divider. Next generation of the team's fixed 32-bit divider lab block.
- Adds: `WIDTH` generalisation, start/busy/done handshake, async reset, divide-by-zero flag, per-operation add/sub counters and a final correction step.
- Retires one quotient bit per cycle.
- Sits beside the ALU datapath as a multi-cycle execution unit.

Parameters:
- `WIDTH`, 32, operand/quotient/remainder width in bits (min 2).
- `CNT_W`, `$clog2(WIDTH+2)`, width of operation counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in `IDLE` or `DONE`.
- `dividend`  in  `WIDTH`  latched on accepted start.
- `divisor`  in  `WIDTH`  latched on accepted start.
- `busy`  out  1  high while in `RUN` or `FIX`.
- `done`  out  1  one-cycle pulse on entry to `DONE`.
- `quotient`  out  `WIDTH`  result, held until next accepted start.
- `remainder`  out  `WIDTH`  result, held until next accepted start.
- `add_ops`  out  `CNT_W`  additions performed, including the correction add.
- `sub_ops`  out  `CNT_W`  subtractions performed.
- `dbz`  out  1  divide-by-zero flag, held with results.

Behaviour:
- Reset state: everything clears asynchronously on `rst`.
  - FSM goes to `IDLE`.
  - `busy`, `done`, `dbz` = 0; `quotient`, `remainder`, `add_ops`, `sub_ops` = 0.
  - A reset mid-operation aborts the operation; no `done` is produced.
- FSM states: `IDLE`, `RUN`, `FIX`, `DONE`.
  - `IDLE`/`DONE` + `start` with `divisor` != 0: latch operands; R (`WIDTH`+1-bit signed) = 0; Q = dividend; counters = 0; iteration counter = 0; go to `RUN`.
  - `IDLE`/`DONE` + `start` with `divisor` == 0: go to `DONE` next cycle; `quotient` = all ones; `remainder` = dividend; counters = 0; `dbz` = 1.
  - `RUN`, one iteration per cycle:
    - Compute s = sign of current R.
    - Shift {R,Q} left 1.
    - If s = 0: R = R − D and `sub_ops`++. Else: R = R + D and `add_ops`++.
    - Q[0] = ~sign(new R).
    - After `WIDTH` iterations, go to `FIX`.
  - `FIX`: if R < 0, R = R + D and `add_ops`++. Load `quotient` = Q and `remainder` = R[`WIDTH`-1:0]. Go to `DONE`.
  - `DONE`: `done` = 1 for this cycle only; outputs hold. Stay in `DONE` until `start`; `DONE` behaves as `IDLE` for acceptance.
- Latency: accepted start at edge N gives `done` high in the cycle after edge N+`WIDTH`+1, i.e. `WIDTH`+2 cycles. A divide-by-zero start gives `done` after 1 cycle.
- Back-to-back: a start asserted during the `done` cycle is accepted.
- `start` during `RUN`/`FIX` is ignored, with no effect on operands or results.
- `dbz` clears on the next accepted non-zero-divisor start.
- Counters never wrap: `add_ops` + `sub_ops` ≤ `WIDTH`+1.

Optional Feature:
- Macro `NRDIV_SIGNED_EN`.
- When defined:
  - Adds input port `sgn` (1 bit), latched with the operands.
  - When `sgn`=1, operands are two's complement. Magnitudes are divided; `FIX` negates the quotient if the operand signs differ and negates the remainder if the dividend is negative, so the quotient truncates toward zero.
  - Most-negative / −1 gives `quotient` = most-negative and `remainder` = 0, with no flag.
  - Divide-by-zero gives `remainder` = dividend and `quotient` = all ones.
  - Latency is unchanged.
- When not defined: the port is absent and operation is unsigned only.

Decomposition:
- Package `nrdiv_pkg` holds:
  - the state enum `nrdiv_state_t` (`IDLE`, `RUN`, `FIX`, `DONE`);
  - the function `nrdiv_cnt_w(width)` returning `$clog2(width+2)`.
- Sub-module `nrdiv_step` is combinational: it takes R, Q, D and returns next R, next Q, and an add/sub select. It is instantiated once in `RUN`.

Test Plan:
- `WIDTH`=4, start with 7÷2 → `done` after 6 cycles; `quotient`=3, `remainder`=1, `add_ops`=2, `sub_ops`=2, `dbz`=0.
- `WIDTH`=4, 15÷1 → `quotient`=15, `remainder`=0, `done` at cycle 6, `busy` high cycles 1–5.
- `WIDTH`=8, 200÷0 → `done` after 1 cycle, `dbz`=1, `quotient`=255, `remainder`=200, both counters 0.
- `WIDTH`=8, 100÷7 with start re-pulsed mid-`RUN` using 9÷3 → second start ignored; `quotient`=14, `remainder`=2.
- `rst` asserted 3 cycles after start, then 9÷3 issued in the `done` cycle of a prior 6÷4 → abort gives all outputs 0, no `done`; back-to-back start gives `quotient`=3, `remainder`=0.
- `NRDIV_SIGNED_EN`, `WIDTH`=8, `sgn`=1: −7÷2 gives `quotient`=−3, `remainder`=−1. Then −128÷−1 gives `quotient`=−128, `remainder`=0.
